msx_ps2_mouse_port: RTL



---
 rtl/msx_ps2_mouse_port.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/msx_ps2_mouse_port.sv
// PS/2 mouse packet stream to MSX joystick-port mouse protocol.
// Motion is accumulated between host reads and served as four strobe-sequenced
// nibbles (X high, X low, Y high, Y low); buttons are reported live.
module msx_ps2_mouse_port #(
    parameter int unsigned TIMEOUT_CYC = 32000,
    parameter int unsigned ACC_W       = 10
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [24:0] ps2_mouse,
    input  logic        strobe,
    output logic [5:0]  data
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic signed [ACC_W:0] ACC_MAX = (ACC_W + 1)'((2 ** (ACC_W - 1)) - 1);
    localparam logic signed [ACC_W:0] S8_MAX  = (ACC_W + 1)'(127);
    localparam logic signed [ACC_W:0] S8_MIN  = (ACC_W + 1)'(-128);

    typedef enum logic [2:0] {
        S_IDLE,
        S_XH,
        S_XL,
        S_YH,
        S_YL
    } state_e;

    state_e state_q, state_d;

    logic                    old_stb_q, old_stb_d;
    logic                    old_tgl_q, old_tgl_d;
    logic                    armed_q, armed_d;
    logic signed [ACC_W-1:0] acc_x_q, acc_x_d;
    logic signed [ACC_W-1:0] acc_y_q, acc_y_d;
    logic [7:0]              snap_x_q, snap_x_d;
    logic [7:0]              snap_y_q, snap_y_d;
    logic                    btn_l_q, btn_l_d;
    logic                    btn_r_q, btn_r_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [5:0]              data_q, data_d;

    logic                    stb_edge_c;
    logic                    pkt_c;
    logic                    latch_c;
    logic                    timeout_c;
    logic signed [8:0]       dx9_c;
    logic signed [8:0]       dy9_c;
    logic signed [ACC_W-1:0] acc_x_base_c;
    logic signed [ACC_W-1:0] acc_y_base_c;
    logic signed [ACC_W:0]   neg_x_c;
    logic signed [ACC_W:0]   pos_y_c;
    logic [3:0]              nib_c;
    logic                    unused_status_c;

    // Accumulate with symmetric saturation at +/-ACC_MAX.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [8:0]       d
    );
        logic signed [ACC_W:0] s;
        s = (ACC_W + 1)'(a) + (ACC_W + 1)'(d);
        if (s > ACC_MAX) begin
            return ACC_W'(ACC_MAX);
        end else if (s < -ACC_MAX) begin
            return ACC_W'(-ACC_MAX);
        end
        return ACC_W'(s);
    endfunction

    // Limit a signed value to the 8-bit two's complement range.
    function automatic logic [7:0] clamp8(input logic signed [ACC_W:0] v);
        if (v > S8_MAX) begin
            return 8'h7F;
        end else if (v < S8_MIN) begin
            return 8'h80;
        end
        return 8'(v);
    endfunction

    assign unused_status_c = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

    // Event detection: strobe edges, packet toggles, read start and timeout.
    always_comb begin
        stb_edge_c = (strobe != old_stb_q);
        pkt_c      = armed_q && (ps2_mouse[24] != old_tgl_q);
        latch_c    = stb_edge_c && ((state_q == S_IDLE) || (state_q == S_YL));
        timeout_c  = (state_q != S_IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
        dx9_c      = {ps2_mouse[4], ps2_mouse[15:8]};
        dy9_c      = {ps2_mouse[5], ps2_mouse[23:16]};
    end

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: strobe edges step the nibble sequence; an edge beats timeout.
    always_comb begin
        state_d = state_q;
        if (stb_edge_c) begin
            case (state_q)
                S_IDLE:  state_d = S_XH;
                S_XH:    state_d = S_XL;
                S_XL:    state_d = S_YH;
                S_YH:    state_d = S_YL;
                S_YL:    state_d = S_XH;
                default: state_d = S_IDLE;
            endcase
        end else if (timeout_c) begin
            state_d = S_IDLE;
        end
    end

    // Datapath next values: snapshots use pre-packet accumulators, then the packet lands.
    always_comb begin
        old_stb_d    = strobe;
        old_tgl_d    = ps2_mouse[24];
        armed_d      = 1'b1;
        neg_x_c      = -((ACC_W + 1)'(acc_x_q));
        pos_y_c      = (ACC_W + 1)'(acc_y_q);
        snap_x_d     = snap_x_q;
        snap_y_d     = snap_y_q;
        acc_x_base_c = acc_x_q;
        acc_y_base_c = acc_y_q;
        if (latch_c) begin
            snap_x_d     = clamp8(neg_x_c);
            snap_y_d     = clamp8(pos_y_c);
            acc_x_base_c = '0;
            acc_y_base_c = '0;
        end
        acc_x_d = acc_x_base_c;
        acc_y_d = acc_y_base_c;
        btn_l_d = btn_l_q;
        btn_r_d = btn_r_q;
        if (pkt_c) begin
            acc_x_d = sat_add(acc_x_base_c, dx9_c);
            acc_y_d = sat_add(acc_y_base_c, dy9_c);
            btn_l_d = ps2_mouse[0];
            btn_r_d = ps2_mouse[1];
        end
        if (stb_edge_c || (state_q == S_IDLE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Output: nibble selected by the upcoming state, buttons active-low.
    always_comb begin
        nib_c = 4'h0;
        case (state_d)
            S_XH:    nib_c = snap_x_d[7:4];
            S_XL:    nib_c = snap_x_d[3:0];
            S_YH:    nib_c = snap_y_d[7:4];
            S_YL:    nib_c = snap_y_d[3:0];
            default: nib_c = 4'h0;
        endcase
        data_d = {~btn_r_d, ~btn_l_d, nib_c};
    end

    // Datapath and output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            old_stb_q <= 1'b0;
            old_tgl_q <= 1'b0;
            armed_q   <= 1'b0;
            acc_x_q   <= '0;
            acc_y_q   <= '0;
            snap_x_q  <= '0;
            snap_y_q  <= '0;
            btn_l_q   <= 1'b0;
            btn_r_q   <= 1'b0;
            cnt_q     <= '0;
            data_q    <= 6'b11_0000;
        end else begin
            old_stb_q <= old_stb_d;
            old_tgl_q <= old_tgl_d;
            armed_q   <= armed_d;
            acc_x_q   <= acc_x_d;
            acc_y_q   <= acc_y_d;
            snap_x_q  <= snap_x_d;
            snap_y_q  <= snap_y_d;
            btn_l_q   <= btn_l_d;
            btn_r_q   <= btn_r_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
        end
    end

    assign data = data_q;

endmodule
